// File: rtl/ctc_ws_gen_if.sv
// Pointer-operation handshake, word-select request and timing outputs of ctc_ws_gen.
// The master drives requests and observes timing; the slave is the generator itself.
interface ctc_ws_gen_if #(
  parameter int CW = 6,
  parameter int PW = 4
);
  logic          op_valid;
  logic [1:0]    op_code;
  logic [PW-1:0] op_imm;
  logic          op_ack;
  logic          ws_load;
  logic [2:0]    ws_mode;
  logic          ws;
  logic          sync;
  logic [CW-1:0] cnt;
  logic [PW-1:0] digit;
  logic          t_dlast;
  logic          t_wlast;
  logic [PW-1:0] ptr;
  logic          ptr_neq;

  modport master (
    output op_valid, op_code, op_imm, ws_load, ws_mode,
    input  op_ack, ws, sync, cnt, digit, t_dlast, t_wlast, ptr, ptr_neq
  );

  modport slave (
    input  op_valid, op_code, op_imm, ws_load, ws_mode,
    output op_ack, ws, sync, cnt, digit, t_dlast, t_wlast, ptr, ptr_neq
  );
endinterface

// File: rtl/ctc_ws_gen.sv
// Serial-word timing generator: bit-time counter, sync window, digit pointer and word-select decode.
// Outputs decode combinationally from state; ops and ws_load are taken only at word end (op_valid held until op_ack).
module ctc_ws_gen #(
  parameter int DIGITS     = 14,
  parameter int BITS       = 4,
  parameter int EXP_DIGITS = 3,
  parameter int SYNC_START = 45,
  parameter int SYNC_LEN   = 10
) (
  input  logic        cph2,
  input  logic        nrst,
  ctc_ws_gen_if.slave bus
);

  localparam int WT = DIGITS * BITS;
  localparam int CW = $clog2(WT);
  localparam int PW = $clog2(DIGITS);
  localparam int BW = $clog2(BITS);

  localparam logic [CW-1:0] CNT_LAST = CW'(WT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(BITS - 1);
  localparam logic [PW-1:0] DIG_LAST = PW'(DIGITS - 1);
  localparam logic [PW-1:0] DIG_PEN  = PW'(DIGITS - 2);
  localparam logic [PW-1:0] EXP_LO   = PW'(EXP_DIGITS);
  localparam logic [PW-1:0] EXP_TOP  = PW'(EXP_DIGITS - 1);
  localparam logic [CW-1:0] SYNC_LO  = CW'(SYNC_START);
  localparam logic [CW-1:0] SYNC_HI  = CW'(SYNC_START + SYNC_LEN - 1);

  generate
    if (DIGITS < 2 || DIGITS > 16) begin : g_bad_digits
      $error("ctc_ws_gen: DIGITS out of range 2..16");
    end
    if (BITS < 2 || BITS > 8) begin : g_bad_bits
      $error("ctc_ws_gen: BITS out of range 2..8");
    end
    if (EXP_DIGITS < 1 || EXP_DIGITS > DIGITS - 2) begin : g_bad_exp
      $error("ctc_ws_gen: EXP_DIGITS out of range 1..DIGITS-2");
    end
    if (SYNC_START < 1 || SYNC_START > WT - 1) begin : g_bad_sync_start
      $error("ctc_ws_gen: SYNC_START out of range 1..WT-1");
    end
    if (SYNC_LEN < 1 || SYNC_START + SYNC_LEN > WT) begin : g_bad_sync_len
      $error("ctc_ws_gen: sync window must be non-empty and end inside the word");
    end
  endgenerate

  typedef enum logic [1:0] {
    OP_SET = 2'b00,
    OP_INC = 2'b01,
    OP_DEC = 2'b10,
    OP_CMP = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    WS_P  = 3'd0,
    WS_WP = 3'd1,
    WS_W  = 3'd2,
    WS_X  = 3'd3,
    WS_XS = 3'd4,
    WS_M  = 3'd5,
    WS_MS = 3'd6,
    WS_S  = 3'd7
  } ws_mode_e;

  logic [CW-1:0] cnt_q;
  logic [BW-1:0] bit_q;
  logic [PW-1:0] digit_q;
  logic          t_dlast;
  logic          t_wlast;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_nxt;
  logic          neq_q;
  logic          neq_nxt;
  logic          op_acc;
  op_e           op_code;

  ws_mode_e      mode_q;
  logic          armed_q;
  logic          ws_hit;

  assign t_dlast = (bit_q == BIT_LAST);
  assign t_wlast = (cnt_q == CNT_LAST);

  // Bit and digit counters run alongside cnt so digit needs no divider for non-power-of-two BITS.
  always_ff @(posedge cph2 or negedge nrst) begin
    if (!nrst) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      digit_q <= '0;
    end else begin
      cnt_q <= t_wlast ? '0 : cnt_q + CW'(1);
      if (t_dlast) begin
        bit_q   <= '0;
        digit_q <= t_wlast ? '0 : digit_q + PW'(1);
      end else begin
        bit_q <= bit_q + BW'(1);
      end
    end
  end

  assign op_code = op_e'(bus.op_code);
  assign op_acc  = bus.op_valid && t_wlast;

  always_comb begin
    ptr_nxt = ptr_q;
    neq_nxt = neq_q;
    unique case (op_code)
      OP_SET: ptr_nxt = (bus.op_imm > DIG_LAST) ? DIG_LAST : bus.op_imm;
      OP_INC: ptr_nxt = (ptr_q == DIG_LAST) ? '0 : ptr_q + PW'(1);
      OP_DEC: ptr_nxt = (ptr_q == '0) ? DIG_LAST : ptr_q - PW'(1);
      OP_CMP: neq_nxt = (ptr_q != bus.op_imm);
    endcase
  end

  // ptr and mode change only at the word boundary, so a word sees one stable pointer.
  always_ff @(posedge cph2 or negedge nrst) begin
    if (!nrst) begin
      ptr_q   <= '0;
      neq_q   <= 1'b0;
      armed_q <= 1'b0;
      mode_q  <= WS_P;
    end else begin
      if (op_acc) begin
        ptr_q <= ptr_nxt;
        neq_q <= neq_nxt;
      end
      if (t_wlast) begin
        armed_q <= bus.ws_load;
        if (bus.ws_load) begin
          mode_q <= ws_mode_e'(bus.ws_mode);
        end
      end
    end
  end

  always_comb begin
    ws_hit = 1'b0;
    unique case (mode_q)
      WS_P:  ws_hit = (digit_q == ptr_q);
      WS_WP: ws_hit = (digit_q <= ptr_q);
      WS_W:  ws_hit = 1'b1;
      WS_X:  ws_hit = (digit_q < EXP_LO);
      WS_XS: ws_hit = (digit_q == EXP_TOP);
      WS_M:  ws_hit = (digit_q >= EXP_LO) && (digit_q <= DIG_PEN);
      WS_MS: ws_hit = (digit_q >= EXP_LO);
      WS_S:  ws_hit = (digit_q == DIG_LAST);
    endcase
  end

  assign bus.op_ack  = op_acc;
  assign bus.ws      = armed_q && ws_hit;
  assign bus.sync    = (cnt_q >= SYNC_LO) && (cnt_q <= SYNC_HI);
  assign bus.cnt     = cnt_q;
  assign bus.digit   = digit_q;
  assign bus.t_dlast = t_dlast;
  assign bus.t_wlast = t_wlast;
  assign bus.ptr     = ptr_q;
  assign bus.ptr_neq = neq_q;

endmodule

// File: tb/tb_ctc_ws_gen.sv
// Table-driven word-by-word bench for ctc_ws_gen at default parameters, with a scoreboard
// queue carrying each word's expected pointer/ws state into the following word.
module tb_ctc_ws_gen;
  localparam int DIGITS = 14;
  localparam int BITS   = 4;
  localparam int WT     = DIGITS * BITS;
  localparam int CW     = 6;
  localparam int PW     = 4;

  typedef struct {
    logic       op;
    logic [1:0] code;
    logic [3:0] imm;
    int         drop;
    logic       ack;
    logic       load;
    logic [2:0] mode;
    int         eptr;
    logic       eneq;
    int         lo;
    int         hi;
  } vec_t;

  typedef struct {
    int   ptr;
    logic neq;
    int   lo;
    int   hi;
  } exp_t;

  logic cph2 = 1'b0;
  logic nrst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sbq[$];
  vec_t vecs[19];
  vec_t idle;

  ctc_ws_gen_if #(.CW(CW), .PW(PW)) bus ();

  ctc_ws_gen #(
    .DIGITS(DIGITS), .BITS(BITS), .EXP_DIGITS(3), .SYNC_START(45), .SYNC_LEN(10)
  ) u_dut (
    .cph2(cph2),
    .nrst(nrst),
    .bus (bus)
  );

  always #5 cph2 = ~cph2;

  task automatic chk(input string name, input int c, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s cnt=%0d actual=%0d required=%0d", name, c, act, exp_v);
    end
  endtask

  task automatic check_cycle(input int c, input exp_t e, input logic ack_exp);
    int d;
    d = c / BITS;
    chk("cnt", c, int'(bus.cnt), c);
    chk("digit", c, int'(bus.digit), d);
    chk("t_dlast", c, int'(bus.t_dlast), int'(c % BITS == BITS - 1));
    chk("t_wlast", c, int'(bus.t_wlast), int'(c == WT - 1));
    chk("sync", c, int'(bus.sync), int'(c >= 45 && c <= 54));
    chk("op_ack", c, int'(bus.op_ack), int'(ack_exp && c == WT - 1));
    chk("ws", c, int'(bus.ws), int'(d >= e.lo && d <= e.hi));
    chk("ptr", c, int'(bus.ptr), e.ptr);
    chk("ptr_neq", c, int'(bus.ptr_neq), int'(e.neq));
  endtask

  // One word: check against the previous word's expectation while driving this word's request.
  task automatic run_word(input vec_t v, input int rst_at);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty actual=0 required=1");
      return;
    end
    e = sbq.pop_front();
    for (int c = 0; c < WT; c++) begin
      @(negedge cph2);
      check_cycle(c, e, v.ack);
      if (c == rst_at) begin
        bus.op_valid = 1'b1;
        bus.op_code  = 2'b00;
        bus.op_imm   = 4'd9;
        bus.ws_load  = 1'b1;
        bus.ws_mode  = 3'd2;
        nrst = 1'b0;
        #1;
        chk("rst_cnt", c, int'(bus.cnt), 0);
        chk("rst_ptr", c, int'(bus.ptr), 0);
        chk("rst_neq", c, int'(bus.ptr_neq), 0);
        chk("rst_ws", c, int'(bus.ws), 0);
        chk("rst_sync", c, int'(bus.sync), 0);
        chk("rst_ack", c, int'(bus.op_ack), 0);
        repeat (3) begin
          @(negedge cph2);
          chk("rst_hold_cnt", c, int'(bus.cnt), 0);
          chk("rst_hold_ack", c, int'(bus.op_ack), 0);
          chk("rst_hold_ws", c, int'(bus.ws), 0);
        end
        bus.op_valid = 1'b0;
        bus.ws_load  = 1'b0;
        @(posedge cph2);
        #2 nrst = 1'b1;
        return;
      end
      if (c == 0) begin
        bus.op_valid = 1'b0;
        bus.ws_load  = 1'b0;
      end
      if (c == 10 && v.op) begin
        bus.op_valid = 1'b1;
        bus.op_code  = v.code;
        bus.op_imm   = v.imm;
      end
      if (c == v.drop) bus.op_valid = 1'b0;
      if (c == 50 && v.load) begin
        bus.ws_load = 1'b1;
        bus.ws_mode = v.mode;
      end
    end
    e.ptr = v.eptr;
    e.neq = v.eneq;
    e.lo  = v.lo;
    e.hi  = v.hi;
    sbq.push_back(e);
  endtask

  initial begin
    exp_t e0;
    bus.op_valid = 1'b0;
    bus.op_code  = 2'b00;
    bus.op_imm   = '0;
    bus.ws_load  = 1'b0;
    bus.ws_mode  = 3'd0;

    //          op code imm drop ack load mode eptr neq lo  hi
    vecs[0]  = '{1, 0,  5, 56, 1, 1, 0,  5, 0,  5,  5};
    vecs[1]  = '{1, 0,  0, 56, 1, 0, 0,  0, 0,  1,  0};
    vecs[2]  = '{1, 2,  0, 56, 1, 0, 0, 13, 0,  1,  0};
    vecs[3]  = '{1, 1,  0, 56, 1, 0, 0,  0, 0,  1,  0};
    vecs[4]  = '{1, 0, 15, 56, 1, 0, 0, 13, 0,  1,  0};
    vecs[5]  = '{1, 0,  3, 56, 1, 0, 0,  3, 0,  1,  0};
    vecs[6]  = '{1, 3,  3, 56, 1, 0, 0,  3, 0,  1,  0};
    vecs[7]  = '{1, 3,  7, 56, 1, 0, 0,  3, 1,  1,  0};
    vecs[8]  = '{0, 0,  0, 56, 0, 1, 2,  3, 1,  0, 13};
    vecs[9]  = '{1, 0,  2, 56, 1, 1, 3,  2, 1,  0,  2};
    vecs[10] = '{1, 1,  0, 56, 1, 1, 1,  3, 1,  0,  3};
    vecs[11] = '{0, 0,  0, 56, 0, 1, 6,  3, 1,  3, 13};
    vecs[12] = '{0, 0,  0, 56, 0, 0, 0,  3, 1,  1,  0};
    vecs[13] = '{1, 2,  0, 30, 0, 1, 4,  3, 1,  2,  2};
    vecs[14] = '{1, 0, 13, 56, 1, 1, 5, 13, 1,  3, 12};
    vecs[15] = '{1, 1,  0, 56, 1, 1, 7,  0, 1, 13, 13};
    vecs[16] = '{1, 0, 14, 56, 1, 1, 0, 13, 1, 13, 13};
    vecs[17] = '{1, 3, 13, 56, 1, 1, 1, 13, 0,  0, 13};
    vecs[18] = '{1, 3,  0, 56, 1, 1, 2, 13, 1,  0, 13};
    idle     = '{0, 0,  0, 56, 0, 0, 0,  0, 0,  1,  0};

    e0.ptr = 0;
    e0.neq = 1'b0;
    e0.lo  = 1;
    e0.hi  = 0;
    sbq.push_back(e0);

    // Reset state with a live request and ws_load asserted.
    repeat (2) @(negedge cph2);
    bus.op_valid = 1'b1;
    bus.ws_load  = 1'b1;
    #1;
    chk("init_cnt", 0, int'(bus.cnt), 0);
    chk("init_ptr", 0, int'(bus.ptr), 0);
    chk("init_neq", 0, int'(bus.ptr_neq), 0);
    chk("init_ack", 0, int'(bus.op_ack), 0);
    chk("init_ws", 0, int'(bus.ws), 0);
    chk("init_sync", 0, int'(bus.sync), 0);
    @(posedge cph2);
    #1;
    chk("init_cnt_held", 0, int'(bus.cnt), 0);
    bus.op_valid = 1'b0;
    bus.ws_load  = 1'b0;
    #1 nrst = 1'b1;

    for (int i = 0; i < 19; i++) run_word(vecs[i], -1);

    // Mid-word reset with ws armed and a request pending, then one clean word.
    run_word(idle, 30);
    sbq.delete();
    sbq.push_back(e0);
    run_word(idle, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
